// File: rtl/fir_decim_avg.sv
// Integrate-and-dump decimator behind the 8-bit FIR: averages each block of DECIM
// valid samples and queues the results in a small FIFO with a valid/ready output.
module fir_decim_avg #(
  parameter int DW         = 8,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DECIM)-1:0] phase,
  output logic                     overflow
);

  localparam int PW  = $clog2(DECIM);
  localparam int AW  = DW + PW;
  localparam int FAW = $clog2(FIFO_DEPTH);

  localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);
  localparam logic [FAW:0]  FULL_COUNT = (FAW + 1)'(FIFO_DEPTH);

  logic [AW-1:0]  acc;
  logic [AW-1:0]  sum;
  logic [DW-1:0]  result;
  logic           dump;

  logic [DW-1:0]  mem [FIFO_DEPTH];
  logic [FAW-1:0] wr_ptr;
  logic [FAW-1:0] rd_ptr;
  logic [FAW:0]   count;

  logic           empty;
  logic           full;
  logic           pop;
  logic           push_req;
  logic           push;
  logic           drop;

  // The accumulator carries PW extra bits, so the block sum never wraps before the shift.
  always_comb begin
    sum      = acc + AW'(in_data);
    result   = sum[AW-1:PW];
    dump     = in_valid && (phase == LAST_PHASE);
    empty    = (count == '0);
    full     = (count == FULL_COUNT);
    pop      = !clear && !empty && out_ready;
    push_req = !clear && dump;
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    out_valid = !empty;
    out_data  = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      phase <= '0;
    end else if (clear) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_valid) begin
      if (dump) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + PW'(1);
      end
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two; count tells full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FAW'(1);
      if (pop)  rd_ptr <= rd_ptr + FAW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FAW + 1)'(1);
        2'b01:   count <= count - (FAW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_decim_avg.sv
// Directed bench for fir_decim_avg (DW=8, DECIM=4, FIFO_DEPTH=4); inputs change and
// outputs are checked on the falling edge.
module tb_fir_decim_avg;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] phase;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  fir_decim_avg #(.DW(8), .DECIM(4), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .phase    (phase),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One valid sample; returns after the edge that consumed it.
  task automatic apply_stimulus(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_block(input logic [7:0] d);
    for (int i = 0; i < 4; i++) apply_stimulus(d);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1 reset
    repeat (3) tick();
    check_output("rst_valid", 32'(out_valid), 0);
    rst = 1'b1;
    tick();
    check_output("rst_out_valid", 32'(out_valid), 0);
    check_output("rst_out_data",  32'(out_data),  0);
    check_output("rst_phase",     32'(phase),     0);
    check_output("rst_overflow",  32'(overflow),  0);

    // 2 basic average, back-to-back
    $display("[TB] basic average");
    out_ready = 1'b1;
    apply_stimulus(8'd1); apply_stimulus(8'd2); apply_stimulus(8'd3);
    check_output("basic_phase3", 32'(phase), 3);
    check_output("basic_novalid", 32'(out_valid), 0);
    apply_stimulus(8'd4);
    check_output("basic_valid1", 32'(out_valid), 1);
    check_output("basic_data1",  32'(out_data),  2);
    check_output("basic_phase0", 32'(phase),     0);
    apply_stimulus(8'd5);
    check_output("basic_onecycle", 32'(out_valid), 0);
    apply_stimulus(8'd6); apply_stimulus(8'd7); apply_stimulus(8'd8);
    check_output("basic_valid2", 32'(out_valid), 1);
    check_output("basic_data2",  32'(out_data),  6);
    tick();
    check_output("basic_drained", 32'(out_valid), 0);
    check_output("basic_zero",    32'(out_data),  0);

    // 3 gaps and extreme value
    $display("[TB] gaps and extreme");
    apply_stimulus(8'd255);
    repeat (2) tick();
    check_output("gap_phase1", 32'(phase), 1);
    apply_stimulus(8'd255);
    tick();
    apply_stimulus(8'd255);
    repeat (3) tick();
    check_output("gap_phase3", 32'(phase), 3);
    check_output("gap_novalid", 32'(out_valid), 0);
    apply_stimulus(8'd255);
    check_output("gap_valid", 32'(out_valid), 1);
    check_output("gap_data",  32'(out_data),  255);
    tick();

    // 4 backpressure and overflow
    $display("[TB] backpressure");
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) send_block(8'(4 * b));
    check_output("bp_no_ovf", 32'(overflow), 0);
    check_output("bp_head",   32'(out_data), 4);
    send_block(8'd20);
    check_output("bp_ovf",    32'(overflow),  1);
    check_output("bp_hold",   32'(out_data),  4);
    check_output("bp_valid",  32'(out_valid), 1);
    tick();
    check_output("bp_stable", 32'(out_data), 4);
    out_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      check_output("bp_order", 32'(out_data), 32'(4 * b));
      tick();
    end
    check_output("bp_empty",    32'(out_valid), 0);
    check_output("bp_ovf_keep", 32'(overflow),  1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_output("clr_ovf",   32'(overflow), 0);
    check_output("clr_phase", 32'(phase),    0);

    // 5 full plus pop in the dump cycle
    $display("[TB] full plus pop");
    out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) send_block(8'(10 * b));
    apply_stimulus(8'd50); apply_stimulus(8'd50); apply_stimulus(8'd50);
    in_valid = 1'b1; in_data = 8'd50; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = '0;
    check_output("fp_no_ovf", 32'(overflow), 0);
    check_output("fp_head20", 32'(out_data), 20);
    tick(); check_output("fp_head30", 32'(out_data), 30);
    tick(); check_output("fp_head40", 32'(out_data), 40);
    tick(); check_output("fp_head50", 32'(out_data), 50);
    tick();
    check_output("fp_empty",   32'(out_valid), 0);
    check_output("fp_no_ovf2", 32'(overflow),  0);

    // 6 reset / clear mid-block
    $display("[TB] reset and clear mid-block");
    apply_stimulus(8'd9); apply_stimulus(8'd9);
    check_output("mid_phase2", 32'(phase), 2);
    rst = 1'b0;
    #1;
    check_output("mid_async_phase", 32'(phase), 0);
    tick();
    rst = 1'b1;
    tick();
    check_output("mid_rst_phase", 32'(phase),     0);
    check_output("mid_rst_empty", 32'(out_valid), 0);
    send_block(8'd1);
    check_output("mid_rst_data", 32'(out_data), 1);
    tick();
    apply_stimulus(8'd9); apply_stimulus(8'd9);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_output("mid_clr_phase", 32'(phase), 0);
    send_block(8'd1);
    check_output("mid_clr_data", 32'(out_data), 1);
    tick();
    out_ready = 1'b0;
    send_block(8'd3);
    check_output("clr_fifo_pre", 32'(out_valid), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_output("clr_fifo_empty", 32'(out_valid), 0);
    check_output("clr_fifo_data",  32'(out_data),  0);
    out_ready = 1'b1;
    apply_stimulus(8'd2); apply_stimulus(8'd2); apply_stimulus(8'd2);
    in_valid = 1'b1; in_data = 8'd2; clear = 1'b1;
    tick();
    in_valid = 1'b0; in_data = '0; clear = 1'b0;
    check_output("clr_dump_nopush", 32'(out_valid), 0);
    check_output("clr_dump_phase",  32'(phase),     0);
    tick();
    check_output("clr_dump_late", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
